// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the fetch-side redirect/stall sequencer.
//   state_t  : sequencer states (warm-up, normal run, load-use stall, redirect flush)
//   PC_INC   : byte increment between sequential fetches
//   PC_W_DEF : default PC width
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_STALL  = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    localparam int PC_INC   = 4;
    localparam int PC_W_DEF = 12;

endpackage

// File: rtl/sat_cnt16.sv
// sat_cnt16: 16-bit event counter that sticks at 0xFFFF.
//   clk   in  core clock
//   rstn  in  asynchronous active-low clear
//   inc   in  count one event this cycle
//   count out current count
module sat_cnt16 (
    input  logic        clk,
    input  logic        rstn,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= 16'h0000;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'h0001;
        end
    end

endmodule

// File: rtl/pipe_flush_ctrl.sv
// pipe_flush_ctrl: fetch-side redirect/stall sequencer for the 5-stage core.
// Turns EX redirects and ID load-use hazards into next-PC selection, PC and
// IF/ID write enables, and IF/ID, ID/EX squash strobes.
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   ex_redirect, ex_target taken branch/jump resolved in EX and its target
//   id_load_use            ID depends on the load currently in EX
//   if_pc                  current fetch PC
//   pc_next, pc_sel        next PC value, set when it is ex_target
//   pc_we, ifid_we         PC and IF/ID write enables
//   ifid_flush, idex_flush NOP into IF/ID, bubble into ID/EX
//   busy                   sequencer is not in normal RUN
//   flush_cnt, stall_cnt   accepted redirects / stalls (counters only exist
//                          when FLUSH_PERF_EN is defined, otherwise tied to 0)
module pipe_flush_ctrl
    import hazard_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int FLUSH_DEPTH = 2,
    parameter int WARMUP      = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            ex_redirect,
    input  logic [PC_W-1:0] ex_target,
    input  logic            id_load_use,
    input  logic [PC_W-1:0] if_pc,
    output logic [PC_W-1:0] pc_next,
    output logic            pc_sel,
    output logic            pc_we,
    output logic            ifid_we,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            busy,
    output logic [15:0]     flush_cnt,
    output logic [15:0]     stall_cnt
);

    // Warm counter holds 0..WARMUP-1, flush counter holds 0..FLUSH_DEPTH-1.
    localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int FCNT_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

    state_t              state, state_nxt;
    logic [WARM_W-1:0]   warm_cnt, warm_nxt;
    logic [FCNT_W-1:0]   fcnt, fcnt_nxt;

    logic redir_acc;
    logic lu_acc;

    // Hazards are only honoured once warm-up is over; load-use only in RUN,
    // and a same-cycle redirect always wins.
    assign redir_acc = (state != ST_WARMUP) && ex_redirect;
    assign lu_acc    = (state == ST_RUN) && id_load_use && !ex_redirect;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_WARMUP;
            warm_cnt <= '0;
            fcnt     <= '0;
        end else begin
            state    <= state_nxt;
            warm_cnt <= warm_nxt;
            fcnt     <= fcnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        warm_nxt  = warm_cnt;
        fcnt_nxt  = fcnt;
        if (redir_acc) begin
            // The redirect cycle itself squashes once; FLUSH covers the rest.
            if (FLUSH_DEPTH > 1) begin
                state_nxt = ST_FLUSH;
                fcnt_nxt  = FCNT_W'(FLUSH_DEPTH - 1);
            end else begin
                state_nxt = ST_RUN;
            end
        end else begin
            case (state)
                ST_WARMUP: begin
                    if (warm_cnt == WARM_W'(WARMUP - 1)) begin
                        state_nxt = ST_RUN;
                    end else begin
                        warm_nxt = warm_cnt + WARM_W'(1);
                    end
                end
                ST_RUN: begin
                    if (lu_acc) begin
                        state_nxt = ST_STALL;
                    end
                end
                ST_STALL: begin
                    state_nxt = ST_RUN;
                end
                ST_FLUSH: begin
                    fcnt_nxt = fcnt - FCNT_W'(1);
                    if (fcnt == FCNT_W'(1)) begin
                        state_nxt = ST_RUN;
                    end
                end
                default: begin
                    state_nxt = ST_WARMUP;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        pc_next    = if_pc + PC_W'(PC_INC);
        pc_sel     = 1'b0;
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        busy       = (state != ST_RUN);
        if (redir_acc) begin
            pc_next    = ex_target;
            pc_sel     = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu_acc) begin
            // Hold PC and IF/ID, bubble the dependent instruction.
            pc_next    = if_pc;
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end else if (state == ST_FLUSH) begin
            ifid_flush = 1'b1;
        end
    end

`ifdef FLUSH_PERF_EN
    sat_cnt16 u_flush_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (redir_acc),
        .count (flush_cnt)
    );

    sat_cnt16 u_stall_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (lu_acc),
        .count (stall_cnt)
    );
`else
    assign flush_cnt = 16'h0000;
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: doc/pipe_flush_ctrl.md
# pipe_flush_ctrl

Pipeline redirect/stall sequencer for the 5-stage core. It consumes the hazard indications raised downstream: taken-branch or jump redirects resolved in EX, and load-use hazards detected in ID. From them it produces the next-PC selection, PC/IF-ID write enables and IF/ID, ID/EX squash strobes. The hazard detectors report that a hazard exists; this block enforces the resulting flush and stall sequence on the fetch side.

## Interface
Parameters:
- PC_W, 12: PC width in bits.
- FLUSH_DEPTH, 2: cycles IF/ID is squashed per redirect, ≥1. Covers registered-IMEM latency.
- WARMUP, 5: cycles after reset during which hazard inputs are ignored, ≥1.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- ex_redirect  in  1  EX resolved a taken branch/jump this cycle
- ex_target  in  PC_W  redirect target, valid with ex_redirect
- id_load_use  in  1  ID instruction depends on load currently in EX
- if_pc  in  PC_W  current fetch PC
- pc_next  out  PC_W  value for PC register
- pc_sel  out  1  pc_next is ex_target
- pc_we  out  1  PC register write enable
- ifid_we  out  1  IF/ID register write enable
- ifid_flush  out  1  load NOP into IF/ID
- idex_flush  out  1  load bubble into ID/EX
- busy  out  1  state ≠ RUN
- flush_cnt  out  16  redirects taken (see Configuration)
- stall_cnt  out  16  load-use stalls taken (see Configuration)

## Operation
- FSM states: WARMUP, RUN, STALL, FLUSH. Reset enters WARMUP with warm counter 0 and flush counter 0.
- WARMUP: all hazard inputs are ignored. After WARMUP cycles in this state, move to RUN.
- Default outputs (no hazard acted on): pc_next=if_pc+4, modulo 2^PC_W, wraps silently. pc_sel=0, pc_we=1, ifid_we=1, both flush strobes 0.
- Outputs are combinational from state and the current-cycle inputs.
- Redirect: applies in RUN, STALL or FLUSH when ex_redirect=1.
  - Same cycle: pc_sel=1, pc_next=ex_target, pc_we=1, ifid_flush=1, idex_flush=1.
  - If FLUSH_DEPTH>1, go to FLUSH with counter = FLUSH_DEPTH-1. Otherwise go to RUN.
- FLUSH: ifid_flush=1, idex_flush=0, PC advances normally. The counter decrements each cycle and the state returns to RUN when it reaches 0. id_load_use is ignored in FLUSH.
- Load-use: applies in RUN with id_load_use=1 and ex_redirect=0.
  - Same cycle: pc_we=0, ifid_we=0, pc_next=if_pc, idex_flush=1. Go to STALL.
- STALL: exactly one further cycle with default outputs, then go to RUN. id_load_use is ignored in STALL, so one hazard produces one stall, never two.
- Priority: ex_redirect beats id_load_use in the same cycle. A redirect during FLUSH restarts the counter and uses the new target.
- busy=1 in WARMUP, STALL and FLUSH.

## Timing
- Reset values of combinational outputs in WARMUP: pc_next=if_pc+4, pc_sel=0, pc_we=1, ifid_we=1, ifid_flush=0, idex_flush=0, busy=1, flush_cnt=0, stall_cnt=0.
- Redirect-to-PC latency is 0 cycles: the target is written at the edge that ends the ex_redirect cycle.
- Redirect bubble cost: FLUSH_DEPTH squashed IF/ID cycles plus 1 ID/EX bubble.
- Load-use cost: 1 cycle.
- rstn asserted mid-FLUSH or mid-STALL returns the block to WARMUP immediately, with no residual strobes.

## Configuration
- FLUSH_PERF_EN defined:
  - flush_cnt increments on each accepted redirect; stall_cnt increments on each accepted load-use stall.
  - Both are 16-bit, saturating at 0xFFFF, and cleared by rstn.
- FLUSH_PERF_EN undefined: both ports stay present and are tied to 0. No counter flops are built.

## Structure
- Package hazard_pkg holds the state enum (WARMUP, RUN, STALL, FLUSH), the PC_INC=4 constant and the PC_W default.
- One sub-module, sat_cnt16: 16-bit saturating counter with inc and async clear. Instantiated twice under FLUSH_PERF_EN.

## Test plan
- Reset, then ex_redirect=1 on cycle 2 -> ignored (pc_sel=0). Same at cycle 6 -> pc_sel=1, pc_next=ex_target.
- RUN, if_pc=0x100, ex_redirect=1, ex_target=0x040 -> pc_next=0x040, ifid_flush high 2 cycles, idex_flush high 1 cycle, busy 1 cycle after.
- RUN, id_load_use held high 2 cycles -> pc_we=0, ifid_we=0, pc_next=0x100, idex_flush=1 for exactly 1 cycle, then resume at 0x104.
- ex_redirect and id_load_use together -> redirect only, no stall, stall_cnt unchanged.
- if_pc=0xFFC -> pc_next=0x000.
- FLUSH_PERF_EN on: 3 redirects and 2 stalls -> flush_cnt=3, stall_cnt=2. rstn pulse mid-FLUSH -> both 0, state WARMUP.
